uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART serial transmitter: the transmit end of the link whose receive path enters through the team's double-flop synchronizer.
- Accepts one parallel word per valid/ready handshake.
- Serialises it as an asynchronous frame: start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits.
- Drives the line from a registered output, so no synchronizer is needed on this end.

Parameters:
- CLK_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock
- nrst  input  1  reset, synchronous, active-low
- tx_data  input  DATA_BITS  word to transmit; sampled only on acceptance
- tx_valid  input  1  producer has a word on tx_data
- tx_ready  output  1  block can accept a word this cycle (registered)
- tx  output  1  serial line, idle high (registered)
- busy  output  1  frame in progress (registered)

Behaviour:
- Reset (nrst=0 at a clk edge): tx=1, tx_ready=1, busy=0, state=IDLE, counters=0, shift register=0. Reset is honoured mid-frame: the frame is abandoned and tx returns high on the next edge.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- Bit timer: 0..CLK_PER_BIT-1, restarts at each bit boundary. Width is clog2(CLK_PER_BIT).
- Bit index: 0..DATA_BITS-1 in DATA; 0..STOP_BITS-1 in STOP.
- IDLE: tx=1, tx_ready=1, busy=0.
  - Acceptance occurs when tx_valid=1 and tx_ready=1 on an edge.
  - On acceptance, tx_data is latched into the shift register and the state moves to START.
  - On the same edge: tx<=0, tx_ready<=0, busy<=1.
- START: tx held 0 for CLK_PER_BIT cycles, then DATA.
- DATA:
  - tx = shreg[0], held CLK_PER_BIT cycles per bit.
  - At each bit boundary, shreg shifts right by one.
  - After bit DATA_BITS-1 completes, move to STOP.
- STOP: tx=1 for STOP_BITS*CLK_PER_BIT cycles, then IDLE. The tx_ready<=1 and busy<=0 update happens on that same edge.
- Latency: the tx falling edge appears on the clk edge that accepts the word (tx is registered), i.e. visible the cycle after valid&ready is sampled.
- Frame length: (1+DATA_BITS+STOP_BITS)*CLK_PER_BIT cycles, from acceptance edge to return to IDLE.
- Back-to-back: minimum spacing between acceptances is frame length + 1 cycle (one IDLE cycle, tx high). No gap is inserted beyond that.
- tx_valid while tx_ready=0 is ignored. The producer holds tx_valid and tx_data until accepted. No word is dropped or double-accepted.
- tx_data changes after acceptance have no effect on the frame in flight.
- tx_valid may drop without acceptance; no side effects.
- tx never glitches: it changes only at bit boundaries or on reset.

Test Plan:
- Single byte, CLK_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, send 0xA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles. busy high for 40 cycles; tx_ready low for 40 cycles, high on cycle 41.
- Back-to-back: tx_valid held high with 0x00 then 0xFF -> second acceptance exactly 41 cycles after the first. Frames are 0,(0 x8),1 and 0,(1 x8),1, separated by exactly one idle-high cycle.
- Data stability: change tx_data from 0x3C to 0xC3 two cycles after acceptance -> line carries 0x3C (LSB first 0,0,1,1,1,1,0,0).
- Reset mid-frame: assert nrst=0 for one edge during data bit 3 -> next edge tx=1, busy=0, tx_ready=1. A following 0x55 is transmitted intact.
- Valid while busy: pulse tx_valid with 0x11 during STOP of the previous frame, then drop it before IDLE -> no second frame; tx stays 1.
- Parameter sweep: DATA_BITS=7, STOP_BITS=2, CLK_PER_BIT=2, send 0x7F -> 0,(1 x7),1,1, each bit 2 cycles, total frame 20 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// UART serial transmitter: accepts one word per valid/ready handshake and sends
// start bit, DATA_BITS data bits LSB first, then STOP_BITS stop bits on a registered line.
module uart_tx #(
  parameter int CLK_PER_BIT = 434,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_timer;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_tx;
  logic                 r_tx_ready;
  logic                 r_busy;

  logic w_accept;
  logic w_bit_end;

  assign w_accept  = tx_valid & r_tx_ready;
  assign w_bit_end = (r_timer == LAST_TICK);

  // Line, handshake and busy are all registered here so tx can only move on a bit boundary.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_idx      <= '0;
      r_shreg    <= '0;
      r_tx       <= 1'b1;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_shreg    <= tx_data;
            r_state    <= START;
            r_timer    <= '0;
            r_tx       <= 1'b0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_idx   <= '0;
            r_state <= DATA;
            r_tx    <= r_shreg[0];
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_shreg <= r_shreg >> 1;
            if (r_idx == LAST_DATA) begin
              r_idx   <= '0;
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
              r_tx  <= r_shreg[1];
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_timer <= '0;
            if (r_idx == LAST_STOP) begin
              r_idx      <= '0;
              r_state    <= IDLE;
              r_tx_ready <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_tx       <= 1'b1;
          r_tx_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign tx_ready = r_tx_ready;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a table of single frames plus hand-written sequences
// for back-to-back, mid-frame reset, valid-while-busy and a second parameter set.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst;
  logic [7:0] a_data;
  logic       a_valid, a_ready, a_tx, a_busy;
  logic [6:0] b_data;
  logic       b_valid, b_ready, b_tx, b_busy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx #(.CLK_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .clk(clk), .nrst(nrst), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .tx(a_tx), .busy(a_busy)
  );

  uart_tx #(.CLK_PER_BIT(2), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .clk(clk), .nrst(nrst), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .tx(b_tx), .busy(b_busy)
  );

  // bits[i] is the i-th bit on the line: start, data LSB first, stop
  typedef struct {
    string      name;
    logic [7:0] data;
    logic [9:0] bits;
  } vec_t;
  vec_t vecs[4];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Returns one sample after the accepting edge.
  task automatic accept_a(input string name, input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (a_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({name, "_ready_wait"}, ok, 1'b1);
    a_data  = d;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic frame_a(input string name, input logic [7:0] d, input logic [9:0] bits);
    accept_a(name, d);
    for (int i = 0; i < 40; i++) begin
      if (i == 2) a_data = ~d;
      chk({name, "_tx"}, a_tx, bits[i/4]);
      if (i == 0 || i == 39) begin
        chk({name, "_busy"}, a_busy, 1'b1);
        chk({name, "_ready"}, a_ready, 1'b0);
      end
      tick();
    end
    chk({name, "_end_ready"}, a_ready, 1'b1);
    chk({name, "_end_busy"}, a_busy, 1'b0);
    chk({name, "_end_tx"}, a_tx, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       exp;
    logic       ok;
    logic [9:0] f1;
    logic [9:0] f2;

    vecs[0] = '{"a5",  8'hA5, 10'h34A};
    vecs[1] = '{"x00", 8'h00, 10'h200};
    vecs[2] = '{"x3c", 8'h3C, 10'h278};
    vecs[3] = '{"xff", 8'hFF, 10'h3FE};

    nrst = 1'b0; a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0;
    tick(); tick();
    chk("rst_a_tx", a_tx, 1'b1);
    chk("rst_a_ready", a_ready, 1'b1);
    chk("rst_a_busy", a_busy, 1'b0);
    chk("rst_b_tx", b_tx, 1'b1);
    chk("rst_b_ready", b_ready, 1'b1);
    chk("rst_b_busy", b_busy, 1'b0);
    nrst = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) frame_a(vecs[v].name, vecs[v].data, vecs[v].bits);

    // Back-to-back with tx_valid held: 0x00 then 0xFF, one idle cycle between
    f1 = 10'h200;
    f2 = 10'h3FE;
    a_data = 8'h00; a_valid = 1'b1;
    tick();
    a_data = 8'hFF;
    for (int k = 0; k < 81; k++) begin
      if (k == 41) a_valid = 1'b0;
      if (k < 40)       exp = f1[k/4];
      else if (k == 40) exp = 1'b1;
      else              exp = f2[(k-41)/4];
      chk("b2b_tx", a_tx, exp);
      if (k == 40) chk("b2b_idle_ready", a_ready, 1'b1);
      if (k == 41) chk("b2b_second_accept", a_ready, 1'b0);
      tick();
    end
    chk("b2b_end_ready", a_ready, 1'b1);
    chk("b2b_end_tx", a_tx, 1'b1);

    // Reset during data bit 3, then a clean 0x55
    accept_a("rst_mid", 8'h55);
    for (int k = 0; k < 17; k++) tick();
    chk("rst_mid_pre_tx", a_tx, 1'b0);
    chk("rst_mid_pre_busy", a_busy, 1'b1);
    nrst = 1'b0;
    tick();
    chk("rst_mid_tx", a_tx, 1'b1);
    chk("rst_mid_busy", a_busy, 1'b0);
    chk("rst_mid_ready", a_ready, 1'b1);
    nrst = 1'b1;
    frame_a("after_rst_55", 8'h55, 10'h2AA);

    // Valid pulsed during the stop bit is ignored
    f1 = 10'h202;
    accept_a("vbusy", 8'h01);
    for (int k = 0; k < 40; k++) begin
      if (k == 37) begin a_valid = 1'b1; a_data = 8'h11; end
      if (k == 38) a_valid = 1'b0;
      chk("vbusy_tx", a_tx, f1[k/4]);
      tick();
    end
    for (int k = 40; k < 60; k++) begin
      chk("vbusy_idle_tx", a_tx, 1'b1);
      chk("vbusy_idle_busy", a_busy, 1'b0);
      tick();
    end

    // DATA_BITS=7, STOP_BITS=2, CLK_PER_BIT=2: 0x7F -> 0,(1 x7),1,1 over 20 cycles
    f1 = 10'h3FE;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (b_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("b_ready_wait", ok, 1'b1);
    b_data = 7'h7F; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk("b_tx", b_tx, f1[k/2]);
      if (k == 0 || k == 19) chk("b_busy", b_busy, 1'b1);
      tick();
    end
    chk("b_end_ready", b_ready, 1'b1);
    chk("b_end_busy", b_busy, 1'b0);
    chk("b_end_tx", b_tx, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
